// File: rtl/vend_pkg.sv
// Shared types and constants for the refund change dispenser.
// Denominations, tube indices, FSM states and eject encodings.
package vend_pkg;

  localparam int DENOM10 = 10;
  localparam int DENOM5  = 5;
  localparam int DENOM1  = 1;

  typedef enum logic [1:0] {
    TUBE10    = 2'd0,
    TUBE5     = 2'd1,
    TUBE1     = 2'd2,
    TUBE_NONE = 2'd3
  } tube_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_EJECT,
    ST_DONE,
    ST_FAULT
  } state_e;

  localparam logic [2:0] EJ_NONE = 3'b000;
  localparam logic [2:0] EJ10    = 3'b001;
  localparam logic [2:0] EJ5     = 3'b010;
  localparam logic [2:0] EJ1     = 3'b100;

  function automatic int denom_of(
    input logic [2:0] oh
  );
    int d;
    d = 0;
    unique case (1'b1)
      oh[0]:   d = DENOM10;
      oh[1]:   d = DENOM5;
      oh[2]:   d = DENOM1;
      default: d = 0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/vend_change_dispenser_if.sv
// Refund request and coin actuator handshakes.
// master = machine side, slave = dispenser.
interface vend_change_dispenser_if #(
  parameter int AMT_W = 6
);
  logic             req_valid;
  logic [AMT_W-1:0] req_amount;
  logic             req_ready;
  logic [2:0]       eject_req;
  logic             eject_ack;

  modport master (
    output req_valid,
    output req_amount,
    output eject_ack,
    input  req_ready,
    input  eject_req
  );

  modport slave (
    input  req_valid,
    input  req_amount,
    input  eject_ack,
    output req_ready,
    output eject_req
  );
endinterface

// File: rtl/vend_coin_tube.sv
// One coin tube inventory: saturating refill add,
// decrement by one per dispensed coin.
module vend_coin_tube #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load_en,
  input  logic [CNT_W-1:0] load_count,
  input  logic             dec_en,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W:0] sum;

  assign sum = {1'b0, count} + {1'b0, load_count};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load_en) begin
      count <= sum[CNT_W] ? '1 : sum[CNT_W-1:0];
    end else if (dec_en && count != '0) begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/vend_change_dispenser.sv
// Greedy refund payout from 10/5/1 tubes, one coin
// per actuator handshake, with timeout fault.
module vend_change_dispenser
  import vend_pkg::*;
#(
  parameter int AMT_W       = 6,
  parameter int CNT_W       = 8,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   reset_n,
  vend_change_dispenser_if.slave bus,
  input  logic                   load_valid,
  input  logic [1:0]             load_tube,
  input  logic [CNT_W-1:0]       load_count,
  output logic                   busy,
  output logic                   done,
  output logic [AMT_W-1:0]       short_amount,
  output logic                   fault,
  output logic [CNT_W-1:0]       cnt10,
  output logic [CNT_W-1:0]       cnt5,
  output logic [CNT_W-1:0]       cnt1
);

  localparam int TMR_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_LAST =
    TMR_W'(ACK_TIMEOUT - 1);
  localparam logic [AMT_W-1:0] D10 = AMT_W'(DENOM10);
  localparam logic [AMT_W-1:0] D5  = AMT_W'(DENOM5);
  localparam logic [AMT_W-1:0] D1  = AMT_W'(DENOM1);

  state_e           state_q, state_d;
  logic [AMT_W-1:0] rem_q, rem_d;
  logic [AMT_W-1:0] short_q, short_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [2:0]       sel_q, sel_d;

  logic             idle;
  logic             accept;
  logic             ack_hit;
  logic             pick10, pick5, pick1;
  logic [AMT_W-1:0] den_amt;
  logic             ld10, ld5, ld1;

  assign idle    = (state_q == ST_IDLE);
  assign accept  = idle && !load_valid && bus.req_valid;
  assign ack_hit = (state_q == ST_EJECT) && bus.eject_ack;
  assign den_amt = AMT_W'(denom_of(sel_q));

  // Mutually exclusive so the selector below stays unique.
  assign pick10 = rem_q >= D10 && cnt10 != '0;
  assign pick5  = !pick10 && rem_q >= D5 && cnt5 != '0;
  assign pick1  = !pick10 && !pick5 &&
                  rem_q >= D1 && cnt1 != '0;

  assign ld10 = idle && load_valid && load_tube == TUBE10;
  assign ld5  = idle && load_valid && load_tube == TUBE5;
  assign ld1  = idle && load_valid && load_tube == TUBE1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      short_q <= '0;
      tmr_q   <= '0;
      sel_q   <= EJ_NONE;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      short_q <= short_d;
      tmr_q   <= tmr_d;
      sel_q   <= sel_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    short_d = short_q;
    tmr_d   = tmr_q;
    sel_d   = sel_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          rem_d   = bus.req_amount;
          short_d = '0;
          state_d = ST_SELECT;
        end
      end
      ST_SELECT: begin
        tmr_d = '0;
        unique case (1'b1)
          pick10: begin
            sel_d   = EJ10;
            state_d = ST_EJECT;
          end
          pick5: begin
            sel_d   = EJ5;
            state_d = ST_EJECT;
          end
          pick1: begin
            sel_d   = EJ1;
            state_d = ST_EJECT;
          end
          default: begin
            sel_d   = EJ_NONE;
            short_d = rem_q;
            state_d = ST_DONE;
          end
        endcase
      end
      ST_EJECT: begin
        if (bus.eject_ack) begin
          rem_d   = rem_q - den_amt;
          tmr_d   = '0;
          sel_d   = EJ_NONE;
          state_d = ST_SELECT;
        end else if (tmr_q == TMR_LAST) begin
          short_d = rem_q;
          sel_d   = EJ_NONE;
          state_d = ST_FAULT;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      ST_FAULT: state_d = ST_FAULT;
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.req_ready = idle && !load_valid;
  assign bus.eject_req =
    (state_q == ST_EJECT) ? sel_q : EJ_NONE;
  assign busy  = !idle && state_q != ST_FAULT;
  assign done  = (state_q == ST_DONE);
  assign fault = (state_q == ST_FAULT);
  assign short_amount = short_q;

  vend_coin_tube #(.CNT_W(CNT_W)) u_tube10 (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_en    (ld10),
    .load_count (load_count),
    .dec_en     (ack_hit && sel_q[0]),
    .count      (cnt10)
  );

  vend_coin_tube #(.CNT_W(CNT_W)) u_tube5 (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_en    (ld5),
    .load_count (load_count),
    .dec_en     (ack_hit && sel_q[1]),
    .count      (cnt5)
  );

  vend_coin_tube #(.CNT_W(CNT_W)) u_tube1 (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_en    (ld1),
    .load_count (load_count),
    .dec_en     (ack_hit && sel_q[2]),
    .count      (cnt1)
  );

endmodule

// File: tb/tb_vend_change_dispenser.sv
// Directed bench for the change dispenser.
// Drives and samples on the falling clock edge.
module tb_vend_change_dispenser;
  import vend_pkg::*;

  logic       clk;
  logic       reset_n;
  logic       load_valid;
  logic [1:0] load_tube;
  logic [7:0] load_count;
  logic       busy;
  logic       done;
  logic [5:0] short_amount;
  logic       fault;
  logic [7:0] cnt10, cnt5, cnt1;

  int total;
  int bad;

  vend_change_dispenser_if #(.AMT_W(6)) bus ();

  vend_change_dispenser #(
    .AMT_W       (6),
    .CNT_W       (8),
    .ACK_TIMEOUT (15)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .bus          (bus),
    .load_valid   (load_valid),
    .load_tube    (load_tube),
    .load_count   (load_count),
    .busy         (busy),
    .done         (done),
    .short_amount (short_amount),
    .fault        (fault),
    .cnt10        (cnt10),
    .cnt5         (cnt5),
    .cnt1         (cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic load(input logic [1:0] t,
                      input logic [7:0] c);
    @(negedge clk);
    load_valid = 1'b1;
    load_tube  = t;
    load_count = c;
    @(negedge clk);
    load_valid = 1'b0;
  endtask

  task automatic request(input logic [5:0] amt);
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_amount = amt;
    @(negedge clk);
    bus.req_valid  = 1'b0;
  endtask

  // Wait for a coin request, then ack after dly cycles.
  task automatic serve(input int dly,
                       output logic [2:0] seen,
                       output bit to);
    seen = 3'b000;
    to   = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.eject_req != 3'b000) begin
        seen = bus.eject_req;
        to   = 1'b0;
        break;
      end
    end
    if (!to) begin
      repeat (dly) @(negedge clk);
      bus.eject_ack = 1'b1;
      @(negedge clk);
      bus.eject_ack = 1'b0;
    end
  endtask

  task automatic wait_done(output logic [5:0] sh,
                           output bit to);
    sh = '0;
    to = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin
        sh = short_amount;
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    total++;
    if ({cnt10, cnt5, cnt1} !== 24'h0) begin
      bad++;
      $display("FAIL reset_cnt got=%h want=0",
               {cnt10, cnt5, cnt1});
    end
    total++;
    if ({bus.eject_req, busy, done, fault,
         short_amount, bus.req_ready} !== 13'h001) begin
      bad++;
      $display("FAIL reset_out got=%h want=001",
               {bus.eject_req, busy, done, fault,
                short_amount, bus.req_ready});
    end
  endtask

  task automatic test_greedy_15();
    logic [2:0] s;
    logic [5:0] sh;
    bit to;
    load(TUBE10, 8'd10);
    load(TUBE5, 8'd10);
    load(TUBE1, 8'd10);
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_amount = 6'd15;
    total++;
    if (bus.req_ready !== 1'b1) begin
      bad++;
      $display("FAIL g15_ready got=%b want=1",
               bus.req_ready);
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL g15_busy got=%b want=1", busy);
    end
    serve(3, s, to);
    total++;
    if (to || s !== 3'b001) begin
      bad++;
      $display("FAIL g15_coin0 got=%b to=%0d want=001",
               s, to);
    end
    serve(3, s, to);
    total++;
    if (to || s !== 3'b010) begin
      bad++;
      $display("FAIL g15_coin1 got=%b to=%0d want=010",
               s, to);
    end
    wait_done(sh, to);
    total++;
    if (to || sh !== 6'd0) begin
      bad++;
      $display("FAIL g15_done short=%0d to=%0d want=0",
               sh, to);
    end
    total++;
    if (cnt10 !== 8'd9 || cnt5 !== 8'd9 ||
        cnt1 !== 8'd10) begin
      bad++;
      $display("FAIL g15_cnt got=%0d/%0d/%0d want=9/9/10",
               cnt10, cnt5, cnt1);
    end
  endtask

  task automatic test_short();
    logic [2:0] s0, s1, s2;
    logic [5:0] sh;
    bit t0, t1, t2, to;
    do_reset();
    load(TUBE5, 8'd1);
    load(TUBE1, 8'd2);
    request(6'd8);
    serve(2, s0, t0);
    serve(2, s1, t1);
    serve(2, s2, t2);
    total++;
    if (t0 || t1 || t2 ||
        {s0, s1, s2} !== 9'b010_100_100) begin
      bad++;
      $display("FAIL short_seq got=%b/%b/%b want=010/100/100",
               s0, s1, s2);
    end
    wait_done(sh, to);
    total++;
    if (to || sh !== 6'd1) begin
      bad++;
      $display("FAIL short_amt got=%0d to=%0d want=1",
               sh, to);
    end
    total++;
    if ({cnt10, cnt5, cnt1} !== 24'h0) begin
      bad++;
      $display("FAIL short_cnt got=%h want=0",
               {cnt10, cnt5, cnt1});
    end
  endtask

  task automatic test_zero();
    do_reset();
    load(TUBE10, 8'd5);
    load(TUBE5, 8'd5);
    load(TUBE1, 8'd5);
    request(6'd0);
    total++;
    if (done !== 1'b0 || bus.eject_req !== 3'b000) begin
      bad++;
      $display("FAIL zero_n1 done=%b ej=%b want=0/000",
               done, bus.eject_req);
    end
    @(negedge clk);
    total++;
    if (done !== 1'b1 || short_amount !== 6'd0 ||
        bus.eject_req !== 3'b000) begin
      bad++;
      $display("FAIL zero_n2 done=%b sh=%0d ej=%b want=1/0/000",
               done, short_amount, bus.eject_req);
    end
    @(negedge clk);
    total++;
    if (done !== 1'b0 || bus.req_ready !== 1'b1) begin
      bad++;
      $display("FAIL zero_idle done=%b rdy=%b want=0/1",
               done, bus.req_ready);
    end
  endtask

  task automatic test_timeout();
    int n;
    n = 0;
    request(6'd10);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.eject_req === 3'b001) n++;
      else if (n > 0) break;
    end
    total++;
    if (n != 15) begin
      bad++;
      $display("FAIL to_hold got=%0d want=15", n);
    end
    bus.req_valid  = 1'b1;
    bus.req_amount = 6'd1;
    #1;
    total++;
    if (fault !== 1'b1 || short_amount !== 6'd10 ||
        bus.req_ready !== 1'b0 || busy !== 1'b0 ||
        bus.eject_req !== 3'b000) begin
      bad++;
      $display("FAIL to_fault f=%b sh=%0d rdy=%b bsy=%b ej=%b",
               fault, short_amount, bus.req_ready, busy,
               bus.eject_req);
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    total++;
    if (fault !== 1'b0 || bus.req_ready !== 1'b1 ||
        cnt10 !== 8'd0) begin
      bad++;
      $display("FAIL to_reset f=%b rdy=%b c10=%0d want=0/1/0",
               fault, bus.req_ready, cnt10);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_load_priority();
    logic [2:0] s;
    logic [5:0] sh;
    bit to;
    int ok;
    load(TUBE1, 8'd100);
    load(TUBE_NONE, 8'd50);
    total++;
    if (cnt10 !== 8'd0 || cnt5 !== 8'd0 ||
        cnt1 !== 8'd100) begin
      bad++;
      $display("FAIL lp_tube3 got=%0d/%0d/%0d want=0/0/100",
               cnt10, cnt5, cnt1);
    end
    @(negedge clk);
    bus.eject_ack = 1'b1;
    @(negedge clk);
    bus.eject_ack = 1'b0;
    total++;
    if (cnt1 !== 8'd100) begin
      bad++;
      $display("FAIL lp_idle_ack got=%0d want=100", cnt1);
    end
    load_valid     = 1'b1;
    load_tube      = TUBE1;
    load_count     = 8'd200;
    bus.req_valid  = 1'b1;
    bus.req_amount = 6'd3;
    #1;
    total++;
    if (bus.req_ready !== 1'b0) begin
      bad++;
      $display("FAIL lp_ready got=%b want=0",
               bus.req_ready);
    end
    @(negedge clk);
    load_valid = 1'b0;
    #1;
    total++;
    if (cnt1 !== 8'd255 || bus.req_ready !== 1'b1 ||
        busy !== 1'b0) begin
      bad++;
      $display("FAIL lp_sat c1=%0d rdy=%b bsy=%b want=255/1/0",
               cnt1, bus.req_ready, busy);
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
    load_valid    = 1'b1;
    load_tube     = TUBE10;
    load_count    = 8'd7;
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL lp_accept bsy=%b want=1", busy);
    end
    ok = 0;
    for (int i = 0; i < 3; i++) begin
      serve(1, s, to);
      load_valid = 1'b0;
      if (!to && s === 3'b100) ok++;
    end
    total++;
    if (ok != 3) begin
      bad++;
      $display("FAIL lp_coins got=%0d want=3", ok);
    end
    wait_done(sh, to);
    total++;
    if (to || sh !== 6'd0 || cnt1 !== 8'd252 ||
        cnt10 !== 8'd0) begin
      bad++;
      $display("FAIL lp_done sh=%0d c1=%0d c10=%0d want=0/252/0",
               sh, cnt1, cnt10);
    end
  endtask

  task automatic test_reset_mid_eject();
    logic [2:0] s;
    bit to;
    int pulses;
    do_reset();
    load(TUBE10, 8'd10);
    load(TUBE5, 8'd10);
    load(TUBE1, 8'd10);
    request(6'd15);
    serve(1, s, to);
    @(negedge clk);
    total++;
    if (to || s !== 3'b001 ||
        bus.eject_req !== 3'b010) begin
      bad++;
      $display("FAIL mid_pre c0=%b ej=%b want=001/010",
               s, bus.eject_req);
    end
    reset_n = 1'b0;
    #1;
    total++;
    if (bus.eject_req !== 3'b000 || busy !== 1'b0 ||
        {cnt10, cnt5, cnt1} !== 24'h0) begin
      bad++;
      $display("FAIL mid_async ej=%b bsy=%b cnt=%h want=0",
               bus.eject_req, busy, {cnt10, cnt5, cnt1});
    end
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 2) reset_n = 1'b1;
      if (done) pulses++;
    end
    total++;
    if (pulses != 0) begin
      bad++;
      $display("FAIL mid_done got=%0d want=0", pulses);
    end
  endtask

  initial begin
    total          = 0;
    bad            = 0;
    reset_n        = 1'b0;
    load_valid     = 1'b0;
    load_tube      = 2'd0;
    load_count     = 8'd0;
    bus.req_valid  = 1'b0;
    bus.req_amount = 6'd0;
    bus.eject_ack  = 1'b0;
    #1;
    test_reset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    test_greedy_15();
    test_short();
    test_zero();
    test_timeout();
    test_load_priority();
    test_reset_mid_eject();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vend_change_dispenser.md
Name: vend_change_dispenser

Overview:
- Controller that sequences refund payout for the vending machine after the S3 settle state.
- Accepts a refund amount over valid/ready and pays it out greedily from three coin tubes (10, 5, 1).
- Drives one tube actuator at a time with a req/ack handshake and tracks per-tube inventory.
- Reports any undispensed remainder and latches a fault on actuator timeout.

Parameters:
- AMT_W, 6, width of refund amount and remainder.
- CNT_W, 8, width of each tube inventory counter; saturates at 2^CNT_W-1.
- ACK_TIMEOUT, 15, cycles eject_req may stay high without eject_ack before fault.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  refund request valid.
- req_amount  in  AMT_W  refund amount in coin units.
- req_ready  out  1  high only in IDLE when load_valid=0.
- load_valid  in  1  tube refill strobe, one cycle.
- load_tube  in  2  0=tube10, 1=tube5, 2=tube1, 3=ignored.
- load_count  in  CNT_W  coins added to the selected tube.
- eject_req  out  3  one-hot actuator request: bit0=10, bit1=5, bit2=1.
- eject_ack  in  1  actuator has dropped one coin.
- busy  out  1  high in any state other than IDLE and FAULT.
- done  out  1  one-cycle pulse at the end of a payout.
- short_amount  out  AMT_W  unpaid remainder; valid while done=1 and held until the next accept.
- fault  out  1  sticky actuator-timeout flag.
- cnt10, cnt5, cnt1  out  CNT_W each  current tube inventories.

Behaviour:
- Reset (asynchronous, reset_n=0): state=IDLE; all outputs, counters, remaining and timer are 0. Reset mid-payout abandons it immediately; eject_req drops asynchronously.
- States: IDLE, SELECT, EJECT, DONE, FAULT.
- IDLE:
  - If load_valid=1, add load_count to the chosen tube, saturating at max. The load takes priority, so req_ready=0 that cycle.
  - Otherwise, req_valid&&req_ready latches remaining=req_amount, then go to SELECT.
  - Loads presented outside IDLE are dropped.
- SELECT (one cycle):
  - If remaining==0, go to DONE with short=0.
  - Otherwise pick the largest denomination d with d<=remaining and tube count>0, then go to EJECT.
  - If no denomination qualifies, go to DONE with short=remaining.
- EJECT:
  - eject_req one-hot for d, held stable; timer counts up from 0.
  - On eject_ack: remaining-=d, tube count-=1, timer cleared, eject_req low next cycle, go to SELECT.
  - If the timer reaches ACK_TIMEOUT with no ack: go to FAULT with short=remaining.
  - eject_ack outside EJECT is ignored.
- DONE: done=1 for one cycle with short_amount driven, then IDLE.
- FAULT: fault=1 and eject_req=0; req_ready=0; only reset exits.
- Latency: accept at cycle N, SELECT at N+1, eject_req at N+2 at the earliest. An amount of 0 gives done at N+2. Each coin costs 2 cycles plus ack delay.
- Arithmetic: remaining never underflows because d<=remaining is checked in SELECT; widths are unsigned.

Decomposition:
- Shared package vend_pkg:
  - denomination constants DENOM10/5/1;
  - tube index encoding;
  - FSM state enum;
  - one-hot eject encodings.
- One natural sub-module, vend_coin_tube: a saturating inventory counter with load-add and decrement-on-ack, instantiated three times.

Test Plan:
1. Tubes 10/10/10, req 15 -> eject bit0 then bit1, ack each after 3 cycles. Expect done with short=0, cnt10=9, cnt5=9, cnt1=10.
2. Tubes 0/1/2, req 8 -> ejects 5,1,1. Expect done with short=1 and all tubes 0.
3. Tubes 5/5/5, req 0 -> done at accept+2, no eject_req, short=0.
4. Req 10, never ack -> eject_req bit0 held 15 cycles, then fault=1, short=10, req_ready=0. Then reset_n=0 -> IDLE with fault=0.
5. IDLE, load_valid with tube1 and count 200 while cnt1=100, plus req_valid the same cycle -> cnt1=255 (saturated), req_ready=0. Req accepted the next cycle.
6. Reset asserted mid-EJECT after one coin of a 15 payout -> eject_req=0 immediately, all counters 0, done never pulses.
